// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, addresses InstructionMem and fills the
// IF/ID register, under an IDLE/RUN/HALT control FSM.
module fetch_stage #(
  parameter int unsigned ADDR_W   = 4,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned RESET_PC = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              inStart,
  input  logic              inHalt,
  input  logic              inStall,
  input  logic              inBranchTaken,
  input  logic [ADDR_W-1:0] inBranchTarget,
  input  logic              inFlush,
  input  logic [DATA_W-1:0] inInstruction,
  output logic [ADDR_W-1:0] outPC,
  output logic [DATA_W-1:0] outIfIdInstr,
  output logic [ADDR_W-1:0] outIfIdPCPlus1,
  output logic              outIfIdValid,
  output logic [1:0]        outState
);

  localparam logic [ADDR_W-1:0] PC_RST = ADDR_W'(RESET_PC);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0] pcp1_q, pcp1_d;
  logic              valid_q, valid_d;
  logic [ADDR_W-1:0] pc_plus1;

  // Natural-width add wraps modulo 2^ADDR_W.
  assign pc_plus1 = pc_q + ADDR_W'(1);

  // Next-state: halt beats branch, branch beats stall, stall beats flush.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    pcp1_d  = pcp1_q;
    valid_d = valid_q;
    unique case (state_q)
      ST_IDLE: begin
        pc_d    = PC_RST;
        valid_d = 1'b0;
        if (inStart) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (inHalt) begin
          state_d = ST_HALT;
          instr_d = '0;
          pcp1_d  = '0;
          valid_d = 1'b0;
        end else if (inBranchTaken) begin
          pc_d    = inBranchTarget;
          instr_d = '0;
          pcp1_d  = '0;
          valid_d = 1'b0;
        end else if (inStall) begin
          if (inFlush) begin
            instr_d = '0;
            pcp1_d  = '0;
            valid_d = 1'b0;
          end
        end else if (inFlush) begin
          pc_d    = pc_plus1;
          instr_d = '0;
          pcp1_d  = '0;
          valid_d = 1'b0;
        end else begin
          pc_d    = pc_plus1;
          instr_d = inInstruction;
          pcp1_d  = pc_plus1;
          valid_d = 1'b1;
        end
      end
      ST_HALT: begin
      end
      default: begin
        state_d = ST_IDLE;
        pc_d    = PC_RST;
        instr_d = '0;
        pcp1_d  = '0;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      pc_q    <= PC_RST;
      instr_q <= '0;
      pcp1_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pcp1_q  <= pcp1_d;
      valid_q <= valid_d;
    end
  end

  assign outPC          = pc_q;
  assign outIfIdInstr   = instr_q;
  assign outIfIdPCPlus1 = pcp1_q;
  assign outIfIdValid   = valid_q;
  assign outState       = state_q;

endmodule
